// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RISC-V instruction fetch with a single-outstanding memory
// port, a one-entry hold buffer for decode back-pressure, redirect handling
// that discards stale responses, and the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        BusyF
);

  // FETCH: may issue; WAIT: live request in flight; HOLD: response parked
  // while decode stalls; DROP: request in flight whose data must be discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  // Sequential PC advance wraps naturally at 2^32.
  assign pc_plus4       = pcf_q + 32'd4;
  // Redirect targets are forced onto a word boundary.
  assign target_aligned = PCTargetE & 32'hFFFF_FFFC;

  // Fetch control: next state, next PC, hold-buffer capture and which
  // instruction (fresh response or parked one) is offered to decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    pcf_d         = pcf_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pcf_q;

    unique case (state_q)
      FETCH: begin
        if (PCSrcE) begin
          pcf_d = target_aligned;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (PCSrcE) begin
            pcf_d   = target_aligned;
            state_d = FETCH;
          end else if (StallD) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pcf_q;
            state_d      = HOLD;
          end else begin
            deliver = 1'b1;
            pcf_d   = pc_plus4;
            state_d = FETCH;
          end
        end else if (PCSrcE) begin
          pcf_d   = target_aligned;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_d        = target_aligned;
          hold_instr_d = 32'd0;
          hold_pc_d    = 32'd0;
          state_d      = FETCH;
        end else if (!StallD) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          pcf_d         = pc_plus4;
          state_d       = FETCH;
        end
      end
      DROP: begin
        if (PCSrcE) begin
          pcf_d = target_aligned;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // IF/ID next value: flush beats stall, stall beats load, otherwise bubble.
  always_comb begin
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;

    if (PCSrcE || (!StallD && !deliver)) begin
      instr_d   = NOP_INSTR;
      pcd_d     = 32'd0;
      pcplus4_d = 32'd4;
      valid_d   = 1'b0;
    end else if (!StallD) begin
      instr_d   = deliver_instr;
      pcd_d     = deliver_pc;
      pcplus4_d = deliver_pc + 32'd4;
      valid_d   = 1'b1;
    end
  end

  // State, PC, hold buffer and IF/ID registers; reset abandons any request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= FETCH;
      pcf_q        <= RESET_PC;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
      instr_q      <= NOP_INSTR;
      pcd_q        <= 32'd0;
      pcplus4_q    <= 32'd4;
      valid_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pcplus4_q    <= pcplus4_d;
      valid_q      <= valid_d;
    end
  end

  // A redirect suppresses the request so the old PC is never fetched.
  assign imem_req  = (state_q == FETCH) && !PCSrcE && !RST;
  assign imem_addr = pcf_q;
  assign BusyF     = (state_q == WAIT) || (state_q == DROP);

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcplus4_q;
  assign ValidD    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a transaction-level model of the
// fetch stage (in-flight request, stale flag, parked instruction) is compared
// against the DUT every cycle, with directed scenarios pinned by literals and
// a randomized phase with variable memory latency.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        StallD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, BusyF;

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .StallD     (StallD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .BusyF      (BusyF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, one in-flight request (possibly
  // stale after a redirect), one parked instruction, and the decode view.
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_buf_instr, m_buf_pc;
  logic        m_valid, m_out, m_stale, m_buf;

  // Memory responder: one outstanding read with programmable latency.
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr = 32'd0;

  logic        req_seen = 1'b0;
  logic [31:0] addr_seen = 32'd0;
  logic        cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0093;
      32'h0000_0004: mem_word = 32'h0010_0113;
      32'h0000_0008: mem_word = 32'hDEAD_BEEF;
      32'h0000_0100: mem_word = 32'h0100_0513;
      default:       mem_word = {a[15:0], ~a[31:16]};
    endcase
  endfunction

  function automatic logic exp_req();
    exp_req = !RST && !m_out && !m_buf && !PCSrcE;
  endfunction

  task automatic model_bubble();
    m_instr = NOP;
    m_pcd   = 32'd0;
    m_pcp4  = 32'd4;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc        = RESET_PC;
    m_out       = 1'b0;
    m_stale     = 1'b0;
    m_buf       = 1'b0;
    m_buf_instr = 32'd0;
    m_buf_pc    = 32'd0;
    model_bubble();
  endtask

  // One clock of the fetch stage seen as transactions.
  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                            input logic rv, input logic [31:0] rd);
    logic        issue, live, have;
    logic [31:0] a_instr, a_pc;
    issue   = !m_out && !m_buf && !br;
    live    = m_out && rv && !m_stale;
    if (m_out && rv) m_out = 1'b0;
    have    = m_buf || live;
    a_instr = m_buf ? m_buf_instr : rd;
    a_pc    = m_buf ? m_buf_pc : m_pc;
    if (br) begin
      model_bubble();
      m_buf = 1'b0;
      m_pc  = {tgt[31:2], 2'b00};
      if (m_out) m_stale = 1'b1;
    end else if (st) begin
      if (live) begin
        m_buf       = 1'b1;
        m_buf_instr = rd;
        m_buf_pc    = m_pc;
      end
    end else if (have) begin
      m_instr = a_instr;
      m_pcd   = a_pc;
      m_pcp4  = a_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = a_pc + 32'd4;
      m_buf   = 1'b0;
    end else begin
      model_bubble();
    end
    if (issue) begin
      m_out   = 1'b1;
      m_stale = 1'b0;
    end
  endtask

  // Compare process: every output against the model, mid-cycle.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("imem_req",  32'(imem_req), 32'(exp_req()));
      check("imem_addr", imem_addr, m_pc);
      check("InstrD",    InstrD, m_instr);
      check("PCD",       PCD, m_pcd);
      check("PCPlus4D",  PCPlus4D, m_pcp4);
      check("ValidD",    32'(ValidD), 32'(m_valid));
      check("BusyF",     32'(BusyF), 32'(m_out));
    end
  end

  // One clock: drive at edge+1, sample request at edge+8, advance on edge.
  task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
    RST         = rst;
    StallD      = st;
    PCSrcE      = br;
    PCTargetE   = tgt;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hBAD0_BAD0;
    if (rst) model_reset();
    #7;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    @(posedge CLK);
    if (!rst) model_step(st, br, tgt, imem_rvalid, imem_rdata);
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (req_seen && !rst) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat - 1;
      mem_addr = addr_seen;
    end
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (ValidD !== 1'b1 && n < budget) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check(name, 32'(ValidD), 32'd1);
  endtask

  initial begin
    logic        st, br;
    logic [31:0] tgt;

    @(posedge CLK);
    #1;
    cmp_en = 1'b1;

    // Reset state.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("rst_InstrD",   InstrD, NOP);
    check("rst_PCD",      PCD, 32'd0);
    check("rst_PCPlus4D", PCPlus4D, 32'd4);
    check("rst_ValidD",   32'(ValidD), 32'd0);
    check("rst_addr",     imem_addr, RESET_PC);
    check("rst_req",      32'(imem_req), 32'd0);

    // Two fetches with a 1-cycle memory, bubble in between.
    mem_lat = 1;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("first_req", {31'd0, req_seen} ^ addr_seen, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("i0_instr", InstrD, 32'h0000_0093);
    check("i0_pcd",   PCD, 32'h0);
    check("i0_valid", 32'(ValidD), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("bubble_valid", 32'(ValidD), 32'd0);
    check("bubble_instr", InstrD, NOP);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("i1_instr", InstrD, 32'h0010_0113);
    check("i1_pcd",   PCD, 32'h4);
    check("i1_pcp4",  PCPlus4D, 32'h8);

    // Decode stall while the response for 0x8 arrives, held 3 cycles.
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("hold_instr",  InstrD, 32'h0010_0113);
      check("hold_no_req", 32'(req_seen), 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("held_instr", InstrD, 32'hDEAD_BEEF);
    check("held_pcd",   PCD, 32'h8);

    // Redirect to 0x103 while waiting on 0x10 with a 3-cycle memory.
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    mem_lat = 3;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("wait_addr", addr_seen, 32'h10);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    check("redir_valid", 32'(ValidD), 32'd0);
    check("redir_addr",  imem_addr, 32'h100);
    check("redir_busy",  32'(BusyF), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("stale_dropped", 32'(ValidD), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("refetch_req",  32'(req_seen), 32'd1);
    check("refetch_addr", addr_seen, 32'h100);
    wait_valid(10, "redir_timeout");
    check("redir_pcd",   PCD, 32'h100);
    check("redir_instr", InstrD, 32'h0100_0513);

    // Redirect coincident with response and stall.
    mem_lat = 1;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    check("flush_instr", InstrD, NOP);
    check("flush_valid", 32'(ValidD), 32'd0);
    check("flush_pcd",   PCD, 32'd0);
    check("flush_addr",  imem_addr, 32'h200);
    check("flush_busy",  32'(BusyF), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("flush_fetch", addr_seen, 32'h200);
    wait_valid(6, "flush_timeout");

    // PC wrap at the top of the address space (unaligned target).
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    wait_valid(6, "wrap_timeout");
    check("wrap_pcd",  PCD, 32'hFFFF_FFFC);
    check("wrap_pcp4", PCPlus4D, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset mid-WAIT; the response arrives while reset is held.
    mem_lat = 3;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("rst2_valid", 32'(ValidD), 32'd0);
    check("rst2_instr", InstrD, NOP);
    check("rst2_addr",  imem_addr, RESET_PC);
    check("rst2_busy",  32'(BusyF), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("rst2_req",   32'(req_seen), 32'd1);
    check("rst2_raddr", addr_seen, RESET_PC);

    // Randomized traffic: stalls, redirects, latencies 1..4, rare resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'd0);
      end else begin
        mem_lat = $urandom_range(1, 4);
        st      = ($urandom_range(0, 3) == 0);
        br      = ($urandom_range(0, 9) == 0);
        tgt     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
        cycle(1'b0, st, br, tgt);
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
